// File: rtl/team_04_pkg.sv
// Shared types and scan-classification helpers for the team 04 keypad scanner.
package team_04_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } fsm_state_t;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_res_t;

    // Bit index of the scan vector is col*4 + row, so it doubles as the key code.
    function automatic scan_res_t classify(input logic [15:0] bits);
        int n;
        n = $countones(bits);
        if (n == 0) return RES_NONE;
        else if (n == 1) return RES_SINGLE;
        else return RES_MULTI;
    endfunction

    function automatic key_code_t first_key(input logic [15:0] bits);
        key_code_t k;
        k = '0;
        for (int i = 15; i >= 0; i--) begin
            if (bits[i]) k = 4'(i);
        end
        return k;
    endfunction

endpackage

// File: rtl/team_04_sync2.sv
// Parameterised-width two-flop synchronizer with synchronous active-high reset.
module team_04_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/team_04_keypad_scanner.sv
// 4x4 keypad scanner: column strobing, full-scan debounce and key strobe generation.
// Optional auto-repeat while a key is held is enabled by defining TEAM04_KEYPAD_REPEAT_EN.
module team_04_keypad_scanner
    import team_04_pkg::*;
#(
    parameter int SCAN_DIV       = 40000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 125
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output key_code_t key_code,
    output logic      key_valid,
    output logic      key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]       rows_sync;
    logic [DIV_W-1:0] dwell_q, dwell_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       col_out_q, col_out_d;
    logic [11:0]      acc_q, acc_d;
    fsm_state_t       state_q, state_d;
    key_code_t        cand_q, cand_d;
    key_code_t        code_q, code_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic             valid_q, valid_d;

    logic             sample;
    logic             scan_done;
    logic [15:0]      scan_bits;
    scan_res_t        res;
    key_code_t        hit;
    logic             same_key;

    team_04_sync2 #(.WIDTH(4)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row_in),
        .q_o (rows_sync)
    );

    assign sample    = en && (dwell_q == DIV_W'(SCAN_DIV - 1));
    assign scan_done = sample && (col_q == 2'd3);
    // Column 3 is evaluated straight from the synchronizer, not from the accumulator.
    assign scan_bits = {rows_sync, acc_q};
    assign res       = classify(scan_bits);
    assign hit       = first_key(scan_bits);
    assign same_key  = (res == RES_SINGLE) && (hit == cand_q);

    always_comb begin
        dwell_d   = dwell_q;
        col_d     = col_q;
        acc_d     = acc_q;
        col_out_d = 4'b0000;
        if (en) begin
            if (dwell_q == DIV_W'(SCAN_DIV - 1)) begin
                dwell_d = '0;
                col_d   = col_q + 2'd1;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
            col_out_d = 4'b0001 << col_d;
            if (sample) begin
                case (col_q)
                    2'd0:    acc_d[3:0]  = rows_sync;
                    2'd1:    acc_d[7:4]  = rows_sync;
                    2'd2:    acc_d[11:8] = rows_sync;
                    default: acc_d       = acc_q;
                endcase
            end
        end else begin
            dwell_d = '0;
            col_d   = 2'd0;
        end
    end

`ifdef TEAM04_KEYPAD_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_SCANS + 1);
    logic [RP_W-1:0] rpt_q, rpt_d;
`else
    logic unused_repeat_param;
    assign unused_repeat_param = (REPEAT_SCANS > 0);
`endif

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
`ifdef TEAM04_KEYPAD_REPEAT_EN
        rpt_d   = rpt_q;
`endif
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
`ifdef TEAM04_KEYPAD_REPEAT_EN
            rpt_d   = '0;
`endif
        end else if (scan_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (res == RES_SINGLE) begin
                        cand_d = hit;
                        cnt_d  = DB_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            code_d  = hit;
                            valid_d = 1'b1;
                            state_d = ST_PRESSED;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (same_key) begin
                        if (cnt_q == DB_W'(DEBOUNCE_SCANS - 1)) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_PRESSED;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (res == RES_NONE) begin
`ifdef TEAM04_KEYPAD_REPEAT_EN
                        rpt_d = '0;
`endif
                        if (DEBOUNCE_SCANS == 1) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d   = DB_W'(1);
                            state_d = ST_RELEASE;
                        end
                    end
`ifdef TEAM04_KEYPAD_REPEAT_EN
                    else if (same_key) begin
                        if (rpt_q == RP_W'(REPEAT_SCANS - 1)) begin
                            valid_d = 1'b1;
                            rpt_d   = '0;
                        end else begin
                            rpt_d = rpt_q + 1'b1;
                        end
                    end
`endif
                end
                ST_RELEASE: begin
                    if (res == RES_NONE) begin
                        if (cnt_q == DB_W'(DEBOUNCE_SCANS - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q   <= '0;
            col_q     <= 2'd0;
            col_out_q <= 4'b0000;
            acc_q     <= '0;
            state_q   <= ST_IDLE;
            cand_q    <= '0;
            code_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            col_out_q <= col_out_d;
            acc_q     <= acc_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
        end
    end

`ifdef TEAM04_KEYPAD_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) rpt_q <= '0;
        else     rpt_q <= rpt_d;
    end
`endif

    assign col_out   = col_out_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);

endmodule
